// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction assembler and the control decoder:
// mnemonic kinds, op/func codes, NOP, and the assembler FSM state type.
package mips_isa_pkg;

    // Codes 0-13 are legal mnemonics; 14 and 15 are illegal.
    typedef enum logic [3:0] {
        KindAdd  = 4'd0,
        KindSub  = 4'd1,
        KindAnd  = 4'd2,
        KindOr   = 4'd3,
        KindXor  = 4'd4,
        KindNor  = 4'd5,
        KindAddi = 4'd6,
        KindAndi = 4'd7,
        KindOri  = 4'd8,
        KindXori = 4'd9,
        KindLw   = 4'd10,
        KindSw   = 4'd11,
        KindBeq  = 4'd12,
        KindBne  = 4'd13
    } inst_kind_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;

    localparam logic [5:0] FuncAdd = 6'b100000;
    localparam logic [5:0] FuncSub = 6'b100010;
    localparam logic [5:0] FuncAnd = 6'b100100;
    localparam logic [5:0] FuncOr  = 6'b100101;
    localparam logic [5:0] FuncXor = 6'b100110;
    localparam logic [5:0] FuncNor = 6'b100111;

    localparam logic [31:0] InstNop = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StPad  = 2'd2,
        StDone = 2'd3
    } asm_state_e;

    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] func);
        return {OpRtype, rs, rt, rd, 5'b00000, func};
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/inst_assembler_if.sv
// Symbolic-instruction stream into the assembler: valid/ready handshake plus fields.
interface inst_assembler_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;

    modport master (
        output in_valid, in_last, in_kind, in_rs, in_rt, in_rd, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, in_kind, in_rs, in_rt, in_rd, in_imm,
        output in_ready
    );

endinterface

// File: rtl/inst_encode.sv
// Combinational encoder: symbolic {kind, rs, rt, rd, imm} -> 32-bit MIPS word and legal flag.
module inst_encode
    import mips_isa_pkg::*;
(
    input  logic [3:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    always_comb begin
        word_o  = InstNop;
        legal_o = 1'b1;
        case (kind_i)
            KindAdd:  word_o = pack_r(rs_i, rt_i, rd_i, FuncAdd);
            KindSub:  word_o = pack_r(rs_i, rt_i, rd_i, FuncSub);
            KindAnd:  word_o = pack_r(rs_i, rt_i, rd_i, FuncAnd);
            KindOr:   word_o = pack_r(rs_i, rt_i, rd_i, FuncOr);
            KindXor:  word_o = pack_r(rs_i, rt_i, rd_i, FuncXor);
            KindNor:  word_o = pack_r(rs_i, rt_i, rd_i, FuncNor);
            KindAddi: word_o = pack_i(OpAddi, rs_i, rt_i, imm_i);
            KindAndi: word_o = pack_i(OpAndi, rs_i, rt_i, imm_i);
            KindOri:  word_o = pack_i(OpOri, rs_i, rt_i, imm_i);
            KindXori: word_o = pack_i(OpXori, rs_i, rt_i, imm_i);
            KindLw:   word_o = pack_i(OpLw, rs_i, rt_i, imm_i);
            KindSw:   word_o = pack_i(OpSw, rs_i, rt_i, imm_i);
            KindBeq:  word_o = pack_i(OpBeq, rs_i, rt_i, imm_i);
            KindBne:  word_o = pack_i(OpBne, rs_i, rt_i, imm_i);
            default:  legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/inst_assembler.sv
// Streaming MIPS assembler: encodes one symbolic instruction per handshake and writes it to
// consecutive imem words. Define ASM_NOP_PAD_EN to NOP-fill the memory tail before done.
module inst_assembler
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    inst_assembler_if.slave   in_bus,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              err_kind,
    output logic              err_ovf,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   MaxCount = (ADDR_W + 1)'((2 ** ADDR_W) - BASE_ADDR);

    asm_state_e        state_q;
    logic              in_ready_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              fire;
    logic              full;

    inst_encode u_encode (
        .kind_i  (in_bus.in_kind),
        .rs_i    (in_bus.in_rs),
        .rt_i    (in_bus.in_rt),
        .rd_i    (in_bus.in_rd),
        .imm_i   (in_bus.in_imm),
        .word_o  (enc_word),
        .legal_o (enc_legal)
    );

    assign in_bus.in_ready = in_ready_q;
    assign fire            = in_bus.in_valid && in_ready_q;
    // Counter reaching the top of memory means the address counter has wrapped.
    assign full            = (word_count == MaxCount);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b0;
            addr_q     <= BaseAddr;
            imem_we    <= 1'b0;
            imem_addr  <= BaseAddr;
            imem_wdata <= 32'h0;
            done       <= 1'b0;
            err_kind   <= 1'b0;
            err_ovf    <= 1'b0;
            word_count <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    // done trails DONE entry by a cycle so the final write has drained.
                    if (state_q == StDone) begin
                        done <= 1'b1;
                    end
                    if (start) begin
                        state_q    <= StLoad;
                        in_ready_q <= 1'b1;
                        addr_q     <= BaseAddr;
                        done       <= 1'b0;
                        err_kind   <= 1'b0;
                        err_ovf    <= 1'b0;
                        word_count <= '0;
                    end
                end
                StLoad: begin
                    if (fire) begin
                        if (!enc_legal) begin
                            err_kind <= 1'b1;
                        end else if (full) begin
                            err_ovf    <= 1'b1;
                            in_ready_q <= 1'b0;
                            state_q    <= StDone;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= addr_q;
                            imem_wdata <= enc_word;
                            addr_q     <= addr_q + 1'b1;
                            word_count <= word_count + 1'b1;
                        end
                        if (in_bus.in_last && !(enc_legal && full)) begin
                            in_ready_q <= 1'b0;
`ifdef ASM_NOP_PAD_EN
                            state_q    <= StPad;
`else
                            state_q    <= StDone;
`endif
                        end
                    end
                end
`ifdef ASM_NOP_PAD_EN
                StPad: begin
                    if (full) begin
                        state_q <= StDone;
                    end else begin
                        imem_we    <= 1'b1;
                        imem_addr  <= addr_q;
                        imem_wdata <= InstNop;
                        addr_q     <= addr_q + 1'b1;
                        word_count <= word_count + 1'b1;
                    end
                end
`endif
                default: begin
                    state_q    <= StIdle;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_assembler.sv
// Scoreboard bench for inst_assembler with an 8-word memory; expected writes are queued
// when instructions are accepted and popped as imem_we pulses are observed.
module tb_inst_assembler;
    import mips_isa_pkg::*;

    localparam int unsigned AddrW = 3;
    localparam int unsigned Depth = 8;

    typedef struct {
        logic [AddrW-1:0] addr;
        logic [31:0]      data;
        logic [AddrW:0]   cnt;
    } wr_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             imem_we;
    logic [AddrW-1:0] imem_addr;
    logic [31:0]      imem_wdata;
    logic             done;
    logic             err_kind;
    logic             err_ovf;
    logic [AddrW:0]   word_count;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int unsigned m_addr;
    int unsigned m_count;
    logic        m_ek;
    logic        m_eo;
    int          n_checks = 0;
    int          n_fail   = 0;

    inst_assembler_if bus ();

    inst_assembler #(
        .ADDR_W    (AddrW),
        .BASE_ADDR (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_bus     (bus),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .done       (done),
        .err_kind   (err_kind),
        .err_ovf    (err_ovf),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            check_eq("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_eq("imem_addr", 32'(imem_addr), 32'(mon_e.addr));
                check_eq("imem_wdata", imem_wdata, mon_e.data);
                check_eq("word_count_at_write", 32'(word_count), 32'(mon_e.cnt));
            end
        end
    end

    task automatic push_write(input logic [31:0] w);
        exp_q.push_back('{addr: AddrW'(m_addr), data: w, cnt: (AddrW + 1)'(m_count + 1)});
        m_addr++;
        m_count++;
    endtask

    task automatic model_accept(input logic [31:0] w, input logic legal, input logic last);
        logic ovf;
        ovf = 1'b0;
        if (!legal) begin
            m_ek = 1'b1;
        end else if (m_count == Depth) begin
            m_eo = 1'b1;
            ovf  = 1'b1;
        end else begin
            push_write(w);
        end
`ifdef ASM_NOP_PAD_EN
        if (last && !ovf) begin
            while (m_count < Depth) push_write(32'h0);
        end
`else
        if (last && !ovf) begin
            m_addr = m_addr;
        end
`endif
    endtask

    task automatic send(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic last,
                        input logic [31:0] w, input logic legal);
        bus.in_valid = 1'b1;
        bus.in_kind  = kind;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_rd    = rd;
        bus.in_imm   = imm;
        bus.in_last  = last;
        check_eq("in_ready_before_xfer", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        model_accept(w, legal, last);
        @(negedge clk);
    endtask

    task automatic start_session();
        start = 1'b1;
        @(posedge clk);
        m_addr  = 0;
        m_count = 0;
        m_ek    = 1'b0;
        m_eo    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_eq("in_ready_after_start", 32'(bus.in_ready), 32'd1);
        check_eq("done_after_start", 32'(done), 32'd0);
        check_eq("count_after_start", 32'(word_count), 32'd0);
        check_eq("err_kind_after_start", 32'(err_kind), 32'd0);
        check_eq("err_ovf_after_start", 32'(err_ovf), 32'd0);
    endtask

    task automatic finish_session();
        int k;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq("done", 32'(done), 32'd1);
        check_eq("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        check_eq("word_count", 32'(word_count), 32'(m_count));
        check_eq("err_kind", 32'(err_kind), 32'(m_ek));
        check_eq("err_ovf", 32'(err_ovf), 32'(m_eo));
        check_eq("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check_eq({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check_eq({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check_eq({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_err_kind"}, 32'(err_kind), 32'd0);
        check_eq({tag, "_err_ovf"}, 32'(err_ovf), 32'd0);
        check_eq({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_kind  = 4'd0;
        bus.in_rs    = 5'd0;
        bus.in_rt    = 5'd0;
        bus.in_rd    = 5'd0;
        bus.in_imm   = 16'd0;
        m_addr       = 0;
        m_count      = 0;
        m_ek         = 1'b0;
        m_eo         = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("idle");

        // Single R-type word, then done two cycles after the last transfer.
        start_session();
        send(KindAdd, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b1, 32'h0022_1820, 1'b1);
        bus.in_valid = 1'b0;
        check_eq("in_ready_after_last", 32'(bus.in_ready), 32'd0);
`ifndef ASM_NOP_PAD_EN
        check_eq("done_n1", 32'(done), 32'd0);
        @(negedge clk);
        check_eq("done_n2", 32'(done), 32'd1);
`endif
        finish_session();

        // Back-to-back I-type / memory / branch words; rd must be ignored.
        start_session();
        send(KindAddi, 5'd0, 5'd1, 5'd31, 16'h0005, 1'b0, 32'h2001_0005, 1'b1);
        send(KindLw,   5'd0, 5'd2, 5'd31, 16'h0004, 1'b0, 32'h8C02_0004, 1'b1);
        send(KindSw,   5'd0, 5'd2, 5'd31, 16'h0008, 1'b0, 32'hAC02_0008, 1'b1);
        send(KindBeq,  5'd1, 5'd2, 5'd31, 16'hFFFF, 1'b1, 32'h1022_FFFF, 1'b1);
        finish_session();

        // Illegal kind between legal words: no write, contiguous addresses, sticky err_kind.
        start_session();
        send(KindOri, 5'd3, 5'd4, 5'd31, 16'h00F0, 1'b0, 32'h3464_00F0, 1'b1);
        send(4'd15,   5'd1, 5'd1, 5'd1,  16'h1111, 1'b0, 32'h0,         1'b0);
        send(KindXor, 5'd6, 5'd7, 5'd5,  16'h0000, 1'b1, 32'h00C7_2826, 1'b1);
        finish_session();

        // Remaining opcodes and func codes.
        start_session();
        send(KindSub,  5'd9,  5'd10, 5'd8,  16'h0000, 1'b0, 32'h012A_4022, 1'b1);
        send(KindAnd,  5'd2,  5'd3,  5'd1,  16'h0000, 1'b0, 32'h0043_0824, 1'b1);
        send(KindOr,   5'd31, 5'd31, 5'd31, 16'h0000, 1'b0, 32'h03FF_F825, 1'b1);
        send(KindNor,  5'd5,  5'd6,  5'd4,  16'h0000, 1'b0, 32'h00A6_2027, 1'b1);
        send(KindAndi, 5'd1,  5'd2,  5'd31, 16'h1234, 1'b0, 32'h3022_1234, 1'b1);
        send(KindXori, 5'd7,  5'd8,  5'd31, 16'hABCD, 1'b0, 32'h38E8_ABCD, 1'b1);
        send(KindBne,  5'd2,  5'd0,  5'd31, 16'h8000, 1'b1, 32'h1440_8000, 1'b1);
        finish_session();

        // Overflow: one more legal word than memory holds, no in_last.
        start_session();
        for (int i = 0; i <= Depth; i++) begin
            send(KindAddi, 5'd0, 5'(i), 5'd0, 16'(i), 1'b0,
                 32'h2000_0000 | (32'(i) << 16) | 32'(i), 1'b1);
        end
        finish_session();
        check_eq("ovf_word_count", 32'(word_count), 32'(Depth));

        // Reset mid-load, then a clean session from the base address.
        start_session();
        send(KindAndi, 5'd1, 5'd2, 5'd0, 16'h1234, 1'b0, 32'h3022_1234, 1'b1);
        send(4'd14,    5'd0, 5'd0, 5'd0, 16'h0000, 1'b0, 32'h0,         1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("err_kind_pre_reset", 32'(err_kind), 32'd1);
        check_eq("pending_pre_reset", 32'(exp_q.size()), 32'd0);
        reset = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_vals("post_reset");
        start_session();
        send(KindAdd, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b1, 32'h0022_1820, 1'b1);
        finish_session();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_assembler.md
# inst_assembler

Streaming MIPS instruction encoder and instruction-memory loader: the inverse of the control decoder. Accepts one symbolic instruction per handshake (mnemonic kind plus register and immediate fields), packs it into a 32-bit MIPS word using the same op/func codes the decoder recognises, and writes it into instruction memory at consecutive word addresses. Used by the bench and the boot path to place programs before the pipelined CPU is released from reset.

## Interface
- `ADDR_W`, 6: instruction-memory word-address width; depth = 2^ADDR_W.
- `BASE_ADDR`, 0: first word address written after `start`.
- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: one-cycle pulse; begins a load session from IDLE or DONE.
- `in_valid` input 1: symbolic instruction present.
- `in_ready` output 1: block can accept; transfer on `in_valid && in_ready`.
- `in_last` input 1: accompanies final instruction of the program.
- `in_kind` input 4: mnemonic code (package enum).
- `in_rs`, `in_rt`, `in_rd` input 5 each: register fields (`in_rd` ignored for I-type/branch/memory).
- `in_imm` input 16: immediate / offset, passed through unmodified.
- `imem_we` output 1: write strobe.
- `imem_addr` output ADDR_W: word address.
- `imem_wdata` output 32: encoded instruction.
- `done` output 1: level, high in DONE.
- `err_kind` output 1: sticky, illegal `in_kind` seen this session.
- `err_ovf` output 1: sticky, program exceeded memory depth.
- `word_count` output ADDR_W+1: words written this session (including pad words).

## Operation
- States: IDLE, LOAD, PAD, DONE. Reset -> IDLE.
- IDLE/DONE: `start` -> LOAD; address counter <= BASE_ADDR, `word_count`, `err_kind`, `err_ovf` cleared. `start` ignored in LOAD/PAD.
- LOAD: `in_ready` = 1. Per accepted transfer, encode and register one write.
- R-type kinds ADD/SUB/AND/OR/XOR/NOR: op 000000, rs, rt, rd, shamt 00000, func 100000/100010/100100/100101/100110/100111.
- I-type: ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, LW 100011, SW 101011, BEQ 000100, BNE 000101; word = {op, rs, rt, imm}.
- Illegal `in_kind`: transfer accepted, no write, no address advance, `err_kind` set.
- After a write, address increments by 1. If a legal instruction is accepted when the address counter has already wrapped past 2^ADDR_W-1 (i.e. `word_count` = 2^ADDR_W - BASE_ADDR): no write, `err_ovf` set, -> DONE immediately.
- Accepted `in_last` (legal or illegal) -> PAD (macro on) or DONE (macro off).
- PAD: `in_ready` = 0; writes 0x00000000 (NOP) to each remaining address up to 2^ADDR_W-1, one per cycle, then -> DONE. If last program word landed at 2^ADDR_W-1, PAD lasts zero write cycles.
- DONE: `in_ready` = 0, `done` = 1, outputs hold their counters/flags.
- Reset mid-session: all state/outputs to reset values; partially written memory is not scrubbed.

## Timing
- Reset values: `in_ready` 0, `imem_we` 0, `imem_addr` BASE_ADDR, `imem_wdata` 0, `done` 0, `err_*` 0, `word_count` 0.
- `start` at edge N -> `in_ready` high from cycle N+1.
- Transfer at edge N -> `imem_we`/`imem_addr`/`imem_wdata` valid for exactly cycle N+1 (1-cycle registered latency); full throughput, one word per cycle.
- `in_last` transfer at edge N -> `in_ready` low from N+1; without pad `done` high from N+2 (after final write drains).
- `word_count` updates together with the write it counts.

## Configuration
- `ASM_NOP_PAD_EN` defined: PAD state compiled in; tail of memory filled with NOPs before `done`.
- Undefined: PAD state absent; LOAD -> DONE on `in_last`; untouched memory left as is.

## Structure
- Shared package `mips_isa_pkg`: `in_kind` enum (4-bit, codes 0-13 legal, 14-15 illegal), op and func constants, NOP constant; decoder side reuses the same constants.
- One sub-module `inst_encode`: purely combinational {kind, rs, rt, rd, imm} -> {word, legal}; FSM, counters, output registers stay in `inst_assembler`.

## Test plan
- start; ADD rd=3 rs=1 rt=2 -> `imem_wdata` 0x00221820 at addr 0, `imem_we` one cycle.
- ADDI rt=1 rs=0 imm=5, LW rt=2 imm=4, SW rt=2 imm=8, BEQ rs=1 rt=2 imm=0xFFFF back-to-back -> 0x20010005, 0x8C020004, 0xAC020008, 0x1022FFFF at addrs 0..3 on consecutive cycles.
- `in_kind`=15 between two legal words -> no write, addresses contiguous, `err_kind`=1 at end.
- ADDR_W=2: five legal words, no `in_last` -> four writes, `err_ovf`=1, `done`=1, `word_count`=4.
- `ASM_NOP_PAD_EN`, ADDR_W=3, 3 words with `in_last` -> 5 writes of 0x00000000 at addrs 3..7, `word_count`=8, then `done`.
- Assert `reset` mid-LOAD -> outputs at reset values next cycle; fresh `start` reloads from BASE_ADDR with cleared flags.
